// File: rtl/branch_predictor_v2_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor:
// RAS operation encoding, counter update and counter reset value.
package bp_pkg;

  typedef enum logic [1:0] {
    RAS_NONE    = 2'd0,
    RAS_PUSH    = 2'd1,
    RAS_POP     = 2'd2,
    RAS_POPPUSH = 2'd3
  } ras_op_e;

  localparam int MAX_CTR_W = 8;

  // Weakly-taken starting point: MSB set, all other bits clear.
  function automatic int unsigned ctr_reset_value(input int unsigned ctr_w);
    return 32'd1 << (ctr_w - 32'd1);
  endfunction

  function automatic logic [MAX_CTR_W-1:0] ctr_next(input logic [MAX_CTR_W-1:0] ctr,
                                                    input logic taken,
                                                    input int unsigned ctr_w);
    logic [MAX_CTR_W-1:0] max_val;
    max_val = MAX_CTR_W'((32'd1 << ctr_w) - 32'd1);
    if (taken)
      return (ctr == max_val) ? ctr : ctr + MAX_CTR_W'(1);
    else
      return (ctr == '0) ? ctr : ctr - MAX_CTR_W'(1);
  endfunction

  function automatic ras_op_e ras_decode(input logic call, input logic ret);
    case ({call, ret})
      2'b10:   return RAS_PUSH;
      2'b01:   return RAS_POP;
      2'b11:   return RAS_POPPUSH;
      default: return RAS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/branch_predictor_v2_if.sv
// Fetch lookup and ALU resolve signals between the pipeline (master)
// and the branch predictor (slave).
interface branch_predictor_v2_if #(
  parameter int GHR_W = 4
);
  logic             pc_vld;
  logic             pc_freeze;
  logic [31:0]      pc;
  logic             bp_taken;
  logic [31:0]      bp_pc;
  logic [GHR_W-1:0] bp_ghr;
  logic             alu_branch;
  logic             alu_cond;
  logic             alu_call;
  logic             alu_return;
  logic             alu_taken;
  logic             alu_flush;
  logic [31:0]      alu_target;
  logic [31:0]      alu_pc;
  logic [GHR_W-1:0] alu_ghr;

  modport master (
    output pc_vld, pc_freeze, pc,
    output alu_branch, alu_cond, alu_call, alu_return, alu_taken, alu_flush,
    output alu_target, alu_pc, alu_ghr,
    input  bp_taken, bp_pc, bp_ghr
  );

  modport slave (
    input  pc_vld, pc_freeze, pc,
    input  alu_branch, alu_cond, alu_call, alu_return, alu_taken, alu_flush,
    input  alu_target, alu_pc, alu_ghr,
    output bp_taken, bp_pc, bp_ghr
  );
endinterface

// File: rtl/branch_predictor_v2_ras.sv
// Circular return-address stack. When restore is high the next state is
// computed from the supplied state/op instead of this stack's own.
module bp_ras
  import bp_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  ras_op_e                op,
  input  logic [31:0]            addr,
  input  logic                   restore,
  input  ras_op_e                restore_op,
  input  logic [31:0]            restore_addr,
  input  logic [DEPTH-1:0][31:0] restore_stack,
  input  logic [PTR_W-1:0]       restore_ptr,
  input  logic [CNT_W-1:0]       restore_count,
  output logic [DEPTH-1:0][31:0] stack,
  output logic [PTR_W-1:0]       ptr,
  output logic [CNT_W-1:0]       count
);

  logic [DEPTH-1:0][31:0] base_stack, nxt_stack;
  logic [PTR_W-1:0]       base_ptr, nxt_ptr, top_idx;
  logic [CNT_W-1:0]       base_count, nxt_count;
  ras_op_e                base_op;
  logic [31:0]            base_addr;

  // ptr names the next free slot; the top entry sits one below it.
  always_comb begin
    base_stack = restore ? restore_stack : stack;
    base_ptr   = restore ? restore_ptr   : ptr;
    base_count = restore ? restore_count : count;
    base_op    = restore ? restore_op    : op;
    base_addr  = restore ? restore_addr  : addr;
    nxt_stack  = base_stack;
    nxt_ptr    = base_ptr;
    nxt_count  = base_count;
    top_idx    = base_ptr - PTR_W'(1);
    if (base_op == RAS_POP && base_count != '0) begin
      nxt_ptr   = top_idx;
      nxt_count = base_count - CNT_W'(1);
    end else if (base_op == RAS_POPPUSH && base_count != '0) begin
      nxt_stack[top_idx] = base_addr;
    end else if (base_op == RAS_PUSH || base_op == RAS_POPPUSH) begin
      nxt_stack[base_ptr] = base_addr;
      nxt_ptr             = base_ptr + PTR_W'(1);
      if (base_count != CNT_W'(DEPTH))
        nxt_count = base_count + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      stack <= '0;
      ptr   <= '0;
      count <= '0;
    end else begin
      stack <= nxt_stack;
      ptr   <= nxt_ptr;
      count <= nxt_count;
    end
  end

endmodule

// File: rtl/branch_predictor_v2.sv
// Fetch-stage branch predictor: gshare counters, tagged BTB with type bits,
// and speculative/architectural return-address stacks repaired on flush.
module branch_predictor_v2
  import bp_pkg::*;
#(
  parameter int GHR_W     = 4,
  parameter int BHT_IDX_W = 6,
  parameter int CTR_W     = 2,
  parameter int BTB_IDX_W = 8,
  parameter int TAG_W     = 22,
  parameter int RAS_DEPTH = 4
) (
  input logic                CLK,
  input logic                RSTN,
  branch_predictor_v2_if.slave bus
);

  localparam int BHT_N = 1 << BHT_IDX_W;
  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_reset_value(CTR_W));

  logic [GHR_W-1:0]  ghr_spec;
  logic [CTR_W-1:0]  ctr [BHT_N];
  logic [BTB_N-1:0]  btb_valid, btb_call, btb_ret, btb_uncond;
  logic [TAG_W-1:0]  btb_tag [BTB_N];
  logic [31:0]       btb_target [BTB_N];

  logic [BTB_IDX_W-1:0] bi, wi;
  logic [BHT_IDX_W-1:0] ci, ui;
  logic                 hit, dir, btb_wr;
  ras_op_e              spec_op, arch_op;

  logic [RAS_DEPTH-1:0][31:0] arch_stack, spec_stack;
  logic [PTR_W-1:0]           arch_ptr, spec_ptr;
  logic [CNT_W-1:0]           arch_count, spec_count;
  logic [31:0]                spec_top;

  assign bi  = bus.pc[2 +: BTB_IDX_W];
  assign ci  = bus.pc[2 +: BHT_IDX_W] ^ BHT_IDX_W'(ghr_spec);
  assign dir = ctr[ci][CTR_W-1];
  assign hit = bus.pc_vld & ~bus.pc_freeze & btb_valid[bi]
             & (btb_tag[bi] == bus.pc[2+BTB_IDX_W +: TAG_W]);

  assign wi     = bus.alu_pc[2 +: BTB_IDX_W];
  assign ui     = bus.alu_pc[2 +: BHT_IDX_W] ^ BHT_IDX_W'(bus.alu_ghr);
  assign btb_wr = bus.alu_branch & bus.alu_taken;

  assign spec_top     = spec_stack[spec_ptr - PTR_W'(1)];
  assign bus.bp_taken = hit & (btb_uncond[bi] | dir);
  assign bus.bp_ghr   = ghr_spec;

  // Returns prefer the speculative stack; an empty stack falls back to the BTB.
  always_comb begin
    bus.bp_pc = '0;
    if (bus.bp_taken)
      bus.bp_pc = (btb_ret[bi] && spec_count != '0) ? spec_top : btb_target[bi];
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)
      ghr_spec <= '0;
    else if (bus.alu_flush)
      ghr_spec <= bus.alu_cond ? {bus.alu_ghr[GHR_W-2:0], bus.alu_taken} : bus.alu_ghr;
    else if (hit && !btb_uncond[bi])
      ghr_spec <= {ghr_spec[GHR_W-2:0], dir};
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < BHT_N; i++)
        ctr[i] <= CTR_INIT;
    end else if (bus.alu_branch && bus.alu_cond) begin
      ctr[ui] <= CTR_W'(ctr_next(MAX_CTR_W'(ctr[ui]), bus.alu_taken, CTR_W));
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)
      btb_valid <= '0;
    else if (btb_wr)
      btb_valid[wi] <= 1'b1;
  end

  // Payload is qualified by btb_valid, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (btb_wr) begin
      btb_tag[wi]    <= bus.alu_pc[2+BTB_IDX_W +: TAG_W];
      btb_target[wi] <= bus.alu_target;
      btb_call[wi]   <= bus.alu_call;
      btb_ret[wi]    <= bus.alu_return;
      btb_uncond[wi] <= ~bus.alu_cond;
    end
  end

  assign spec_op = hit ? ras_decode(btb_call[bi], btb_ret[bi]) : RAS_NONE;
  assign arch_op = bus.alu_branch ? ras_decode(bus.alu_call, bus.alu_return) : RAS_NONE;

  bp_ras #(.DEPTH(RAS_DEPTH)) u_arch_ras (
    .CLK           (CLK),
    .RSTN          (RSTN),
    .op            (arch_op),
    .addr          (bus.alu_pc + 32'd4),
    .restore       (1'b0),
    .restore_op    (RAS_NONE),
    .restore_addr  (32'd0),
    .restore_stack ('0),
    .restore_ptr   ('0),
    .restore_count ('0),
    .stack         (arch_stack),
    .ptr           (arch_ptr),
    .count         (arch_count)
  );

  // On flush the speculative stack adopts the architectural stack's next state.
  bp_ras #(.DEPTH(RAS_DEPTH)) u_spec_ras (
    .CLK           (CLK),
    .RSTN          (RSTN),
    .op            (spec_op),
    .addr          (bus.pc + 32'd4),
    .restore       (bus.alu_flush),
    .restore_op    (arch_op),
    .restore_addr  (bus.alu_pc + 32'd4),
    .restore_stack (arch_stack),
    .restore_ptr   (arch_ptr),
    .restore_count (arch_count),
    .stack         (spec_stack),
    .ptr           (spec_ptr),
    .count         (spec_count)
  );

endmodule

// File: tb/tb_branch_predictor_v2.sv
// Directed testbench for branch_predictor_v2 with hand-computed expectations.
module tb_branch_predictor_v2;

  logic CLK  = 1'b0;
  logic RSTN = 1'b0;
  int   n_compared   = 0;
  int   n_mismatched = 0;

  always #5 CLK = ~CLK;

  branch_predictor_v2_if #(.GHR_W(4)) bus ();

  branch_predictor_v2 #(
    .GHR_W(4), .BHT_IDX_W(6), .CTR_W(2), .BTB_IDX_W(8), .TAG_W(22), .RAS_DEPTH(4)
  ) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  task automatic idle_inputs();
    bus.pc_vld = 0; bus.pc_freeze = 0; bus.pc = '0;
    bus.alu_branch = 0; bus.alu_cond = 0; bus.alu_call = 0; bus.alu_return = 0;
    bus.alu_taken = 0; bus.alu_flush = 0; bus.alu_target = '0; bus.alu_pc = '0;
    bus.alu_ghr = '0;
  endtask

  task automatic begin_cycle();
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic do_reset();
    begin_cycle();
    RSTN = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1;
  endtask

  task automatic resolve(input logic [31:0] a_pc, input logic [31:0] tgt, input logic cond,
                         input logic call, input logic ret, input logic taken,
                         input logic [3:0] ghr);
    begin_cycle();
    bus.alu_branch = 1; bus.alu_pc = a_pc; bus.alu_target = tgt; bus.alu_cond = cond;
    bus.alu_call = call; bus.alu_return = ret; bus.alu_taken = taken; bus.alu_ghr = ghr;
  endtask

  task automatic lookup(input logic [31:0] f_pc, input logic freeze);
    begin_cycle();
    bus.pc_vld = 1; bus.pc = f_pc; bus.pc_freeze = freeze;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    lookup(32'h100, 0);
    n_compared++;
    if (bus.bp_taken !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_taken: got %0b want 0", bus.bp_taken); end
    n_compared++;
    if (bus.bp_pc !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_pc: got %h want 0", bus.bp_pc); end
    n_compared++;
    if (bus.bp_ghr !== 4'b0000) begin n_mismatched++; $display("[TB] FAIL reset_ghr: got %b want 0000", bus.bp_ghr); end
  endtask

  task automatic test_taken_cond();
    do_reset();
    resolve(32'h200, 32'h240, 1, 0, 0, 1, 4'b0000);
    lookup(32'h200, 0);
    n_compared++;
    if (bus.bp_taken !== 1'b1) begin n_mismatched++; $display("[TB] FAIL cond_taken: got %0b want 1", bus.bp_taken); end
    n_compared++;
    if (bus.bp_pc !== 32'h240) begin n_mismatched++; $display("[TB] FAIL cond_target: got %h want 00000240", bus.bp_pc); end
    n_compared++;
    if (bus.bp_ghr !== 4'b0000) begin n_mismatched++; $display("[TB] FAIL cond_ghr_used: got %b want 0000", bus.bp_ghr); end
    begin_cycle();
    #1;
    n_compared++;
    if (bus.bp_ghr !== 4'b0001) begin n_mismatched++; $display("[TB] FAIL cond_ghr_shift: got %b want 0001", bus.bp_ghr); end
  endtask

  task automatic test_counter_saturation();
    do_reset();
    resolve(32'h500, 32'h580, 1, 0, 0, 1, 4'b0001);
    resolve(32'h500, 32'h580, 1, 0, 0, 0, 4'b0000);
    lookup(32'h500, 0);
    n_compared++;
    if (bus.bp_taken !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ctr_dec_once: got %0b want 0", bus.bp_taken); end
    resolve(32'h500, 32'h580, 1, 0, 0, 0, 4'b0000);
    lookup(32'h500, 0);
    n_compared++;
    if (bus.bp_taken !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ctr_dec_twice: got %0b want 0", bus.bp_taken); end
    n_compared++;
    if (bus.bp_pc !== 32'h0) begin n_mismatched++; $display("[TB] FAIL ctr_nt_pc: got %h want 0", bus.bp_pc); end
    for (int i = 0; i < 3; i++)
      resolve(32'h500, 32'h580, 1, 0, 0, 0, 4'b0000);
    resolve(32'h500, 32'h580, 1, 0, 0, 1, 4'b0000);
    lookup(32'h500, 0);
    n_compared++;
    if (bus.bp_taken !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ctr_floor: got %0b want 0", bus.bp_taken); end
    n_compared++;
    if (bus.bp_ghr !== 4'b0000) begin n_mismatched++; $display("[TB] FAIL ctr_ghr_zero: got %b want 0000", bus.bp_ghr); end
    resolve(32'h500, 32'h580, 1, 0, 0, 1, 4'b0000);
    lookup(32'h500, 0);
    n_compared++;
    if (bus.bp_pc !== 32'h580) begin n_mismatched++; $display("[TB] FAIL ctr_recover: got %h want 00000580", bus.bp_pc); end
    resolve(32'h500, 32'h580, 1, 0, 0, 1, 4'b0001);
    resolve(32'h500, 32'h580, 1, 0, 0, 0, 4'b0001);
    resolve(32'h500, 32'h580, 1, 0, 0, 0, 4'b0001);
    lookup(32'h500, 0);
    n_compared++;
    if (bus.bp_ghr !== 4'b0001) begin n_mismatched++; $display("[TB] FAIL ctr_ghr_one: got %b want 0001", bus.bp_ghr); end
    n_compared++;
    if (bus.bp_taken !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ctr_ceiling: got %0b want 0", bus.bp_taken); end
  endtask

  task automatic test_call_return();
    logic [31:0] exp_pc;
    do_reset();
    resolve(32'h300, 32'h800, 0, 1, 0, 1, 4'b0000);
    resolve(32'h400, 32'h999, 0, 0, 1, 1, 4'b0000);
    lookup(32'h300, 0);
    n_compared++;
    if (bus.bp_pc !== 32'h800) begin n_mismatched++; $display("[TB] FAIL call_target: got %h want 00000800", bus.bp_pc); end
    lookup(32'h400, 0);
    n_compared++;
    if (bus.bp_pc !== 32'h304) begin n_mismatched++; $display("[TB] FAIL ret_from_ras: got %h want 00000304", bus.bp_pc); end
    lookup(32'h400, 0);
    n_compared++;
    if (bus.bp_pc !== 32'h999) begin n_mismatched++; $display("[TB] FAIL ret_empty: got %h want 00000999", bus.bp_pc); end
    for (int i = 1; i < 5; i++)
      resolve(32'h300 + 32'(16 * i), 32'h800 + 32'(16 * i), 0, 1, 0, 1, 4'b0000);
    for (int i = 0; i < 5; i++)
      lookup(32'h300 + 32'(16 * i), 0);
    for (int k = 0; k < 6; k++) begin
      exp_pc = (k < 4) ? 32'h344 - 32'(16 * k) : 32'h999;
      lookup(32'h400, 0);
      n_compared++;
      if (bus.bp_pc !== exp_pc) begin n_mismatched++; $display("[TB] FAIL ras_wrap_pop%0d: got %h want %h", k, bus.bp_pc, exp_pc); end
    end
    lookup(32'h300, 0);
    lookup(32'h400, 0);
    n_compared++;
    if (bus.bp_pc !== 32'h304) begin n_mismatched++; $display("[TB] FAIL ras_no_underflow: got %h want 00000304", bus.bp_pc); end
  endtask

  task automatic test_flush_repair();
    do_reset();
    resolve(32'h300, 32'h800, 0, 1, 0, 1, 4'b0000);
    resolve(32'h400, 32'h999, 0, 0, 1, 1, 4'b0000);
    resolve(32'h600, 32'h680, 1, 0, 0, 1, 4'b0000);
    lookup(32'h300, 0);
    begin_cycle();
    bus.alu_flush = 1; bus.alu_cond = 0; bus.alu_ghr = 4'b1011;
    begin_cycle();
    bus.pc_vld = 1; bus.pc = 32'h600;
    bus.alu_branch = 1; bus.alu_flush = 1; bus.alu_cond = 1; bus.alu_taken = 1; bus.alu_call = 1;
    bus.alu_pc = 32'h700; bus.alu_target = 32'h780; bus.alu_ghr = 4'b0010;
    #1;
    n_compared++;
    if (bus.bp_ghr !== 4'b1011) begin n_mismatched++; $display("[TB] FAIL flush_pre_ghr: got %b want 1011", bus.bp_ghr); end
    n_compared++;
    if (bus.bp_pc !== 32'h680) begin n_mismatched++; $display("[TB] FAIL flush_same_hit: got %h want 00000680", bus.bp_pc); end
    lookup(32'h400, 0);
    n_compared++;
    if (bus.bp_ghr !== 4'b0101) begin n_mismatched++; $display("[TB] FAIL flush_ghr: got %b want 0101", bus.bp_ghr); end
    n_compared++;
    if (bus.bp_pc !== 32'h704) begin n_mismatched++; $display("[TB] FAIL flush_ras_top: got %h want 00000704", bus.bp_pc); end
    lookup(32'h400, 0);
    n_compared++;
    if (bus.bp_pc !== 32'h999) begin n_mismatched++; $display("[TB] FAIL flush_ras_depth: got %h want 00000999", bus.bp_pc); end
  endtask

  task automatic test_freeze();
    do_reset();
    resolve(32'h300, 32'h800, 0, 1, 0, 1, 4'b0000);
    resolve(32'h400, 32'h999, 0, 0, 1, 1, 4'b0000);
    resolve(32'h500, 32'h580, 1, 0, 0, 1, 4'b0000);
    lookup(32'h300, 1);
    n_compared++;
    if (bus.bp_taken !== 1'b0) begin n_mismatched++; $display("[TB] FAIL freeze_call_taken: got %0b want 0", bus.bp_taken); end
    n_compared++;
    if (bus.bp_pc !== 32'h0) begin n_mismatched++; $display("[TB] FAIL freeze_call_pc: got %h want 0", bus.bp_pc); end
    lookup(32'h500, 1);
    n_compared++;
    if (bus.bp_taken !== 1'b0) begin n_mismatched++; $display("[TB] FAIL freeze_cond_taken: got %0b want 0", bus.bp_taken); end
    lookup(32'h400, 0);
    n_compared++;
    if (bus.bp_pc !== 32'h999) begin n_mismatched++; $display("[TB] FAIL freeze_no_push: got %h want 00000999", bus.bp_pc); end
    n_compared++;
    if (bus.bp_ghr !== 4'b0000) begin n_mismatched++; $display("[TB] FAIL freeze_no_shift: got %b want 0000", bus.bp_ghr); end
    lookup(32'h500, 0);
    n_compared++;
    if (bus.bp_pc !== 32'h580) begin n_mismatched++; $display("[TB] FAIL unfreeze_hit: got %h want 00000580", bus.bp_pc); end
    begin_cycle();
    #1;
    n_compared++;
    if (bus.bp_ghr !== 4'b0001) begin n_mismatched++; $display("[TB] FAIL unfreeze_shift: got %b want 0001", bus.bp_ghr); end
  endtask

  task automatic test_async_reset();
    do_reset();
    resolve(32'h200, 32'h240, 1, 0, 0, 1, 4'b0000);
    begin_cycle();
    bus.alu_flush = 1; bus.alu_ghr = 4'b1011;
    begin_cycle();
    #1;
    n_compared++;
    if (bus.bp_ghr !== 4'b1011) begin n_mismatched++; $display("[TB] FAIL async_pre_ghr: got %b want 1011", bus.bp_ghr); end
    #1;
    RSTN = 1'b0;
    #1;
    n_compared++;
    if (bus.bp_ghr !== 4'b0000) begin n_mismatched++; $display("[TB] FAIL async_ghr_clear: got %b want 0000", bus.bp_ghr); end
    bus.pc_vld = 1; bus.pc = 32'h200;
    #1;
    n_compared++;
    if (bus.bp_taken !== 1'b0) begin n_mismatched++; $display("[TB] FAIL async_btb_clear: got %0b want 0", bus.bp_taken); end
    @(negedge CLK);
    RSTN = 1'b1;
    lookup(32'h200, 0);
    n_compared++;
    if (bus.bp_taken !== 1'b0) begin n_mismatched++; $display("[TB] FAIL async_after_release: got %0b want 0", bus.bp_taken); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_taken_cond();
    test_counter_saturation();
    test_call_return();
    test_flush_repair();
    test_freeze();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
